// File: rtl/iterative_muldiv_unit.sv
// iterative_muldiv_unit: radix-2 RV32M multiply/divide, one bit per cycle, result held until next start.
module iterative_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CALC  = 2'd1;
    localparam logic [1:0] FIXUP = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op;
    logic              neg_q, neg_r;
    logic [XLEN-1:0]   b_mag, rem;
    logic [2*XLEN-1:0] acc;

    logic              sa, sb, accept, div0, ovf, ge;
    logic [XLEN-1:0]   am, bm, fast_res, rem_nx, q_fix, r_fix, fix_res;
    logic [XLEN:0]     hsum, shifted;
    logic [2*XLEN-1:0] mul_nx, div_nx, prod;

    assign busy = (state == CALC) || (state == FIXUP);
    assign done = state == DONE;

    always_comb begin
        sa       = op_a[XLEN-1] & (funct3 == 3'b001 || funct3 == 3'b010 || funct3 == 3'b100 || funct3 == 3'b110);
        sb       = op_b[XLEN-1] & (funct3 == 3'b001 || funct3 == 3'b100 || funct3 == 3'b110);
        am       = sa ? -op_a : op_a;
        bm       = sb ? -op_b : op_b;
        accept   = start && !flush && (state == IDLE || state == DONE);
        div0     = funct3[2] && op_b == '0;
        ovf      = funct3[2] && !funct3[0] && op_a == {1'b1, {(XLEN-1){1'b0}}} && &op_b;
        fast_res = div0 ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : op_a);
        // multiply: add multiplicand into the upper half, then shift the whole accumulator right
        hsum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
        mul_nx   = {hsum, acc[XLEN-1:1]};
        // divide: dividend bits leave the top of the low half as quotient bits enter at the bottom
        shifted  = {rem, acc[XLEN-1]};
        ge       = shifted >= {1'b0, b_mag};
        rem_nx   = ge ? XLEN'(shifted - {1'b0, b_mag}) : shifted[XLEN-1:0];
        div_nx   = {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], ge};
        prod     = neg_q ? -acc : acc;
        q_fix    = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        r_fix    = neg_r ? -rem : rem;
        fix_res  = op[2] ? (op[1] ? r_fix : q_fix) : (op == 3'b000 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            op     <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_mag  <= '0;
            rem    <= '0;
            acc    <= '0;
            result <= '0;
        end else if (accept) begin
            op    <= funct3;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            b_mag <= bm;
            acc   <= {{XLEN{1'b0}}, am};
            rem   <= '0;
            cnt   <= '0;
            if (div0 || ovf) begin
                state  <= DONE;
                result <= fast_res;
            end else begin
                state <= CALC;
            end
        end else if (flush || state == DONE) begin
            state <= IDLE;
        end else if (state == CALC) begin
            acc   <= op[2] ? div_nx : mul_nx;
            rem   <= op[2] ? rem_nx : rem;
            cnt   <= cnt + 1'b1;
            state <= (cnt == CNT_W'(XLEN-1)) ? FIXUP : CALC;
        end else if (state == FIXUP) begin
            state  <= DONE;
            result <= fix_res;
        end
    end
endmodule
